// File: rtl/seq_debug_cmd_initiator.sv
// Debug command initiator: writes parameters and a command code into the sequencer
// mailbox over Avalon-MM, polls CMD_STATUS until done or poll limit, then reports.
module seq_debug_cmd_initiator #(
  parameter logic [31:0] DEBUG_BASE = 32'h000152a4,
  parameter int          NUM_PARAMS = 4,
  parameter int          POLL_GAP   = 16,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic                     avl_clk,
  input  logic                     avl_reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_code,
  input  logic [3:0]               cmd_nparams,
  input  logic [32*NUM_PARAMS-1:0] cmd_params,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_status,
  output logic                     rsp_timeout,
  output logic [31:0]              avm_address,
  output logic                     avm_write,
  output logic                     avm_read,
  output logic [31:0]              avm_writedata,
  input  logic                     avm_waitrequest,
  input  logic [31:0]              avm_readdata,
  input  logic                     avm_readdatavalid,
  output logic [3:0]               dbg_state
);

  // Handshake: a command is taken on cmd_valid && cmd_ready; Avalon requests hold
  // address/data/strobes until a cycle with !avm_waitrequest; rsp_valid is a one-cycle pulse.

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_WR_PARAM  = 4'd1,
    S_WR_STATUS = 4'd2,
    S_WR_CMD    = 4'd3,
    S_POLL_WAIT = 4'd4,
    S_RD_REQ    = 4'd5,
    S_RD_WAIT   = 4'd6,
    S_WR_CLR    = 4'd7,
    S_DONE      = 4'd8
  } state_t;

  localparam int                GAP_W    = $clog2(POLL_GAP + 1);
  localparam int                LIM_W    = $clog2(POLL_LIMIT + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(POLL_GAP - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(POLL_GAP);
  localparam logic [LIM_W-1:0]  LIM_LAST = LIM_W'(POLL_LIMIT - 1);
  localparam logic [LIM_W-1:0]  LIM_MAX  = LIM_W'(POLL_LIMIT);
  localparam logic [3:0]        NP_MAX   = 4'(NUM_PARAMS);
  localparam logic [31:0]       A_REQ    = DEBUG_BASE + 32'h8;
  localparam logic [31:0]       A_STATUS = DEBUG_BASE + 32'hC;
  localparam logic [31:0]       A_PARAM  = DEBUG_BASE + 32'h10;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [31:0]             r_code;
  logic [3:0]              r_nparams;
  logic [3:0]              r_idx;
  logic [32*NUM_PARAMS-1:0] r_params;
  logic [GAP_W-1:0]        r_gap_cnt;
  logic [LIM_W-1:0]        r_poll_cnt;
  logic [31:0]             r_rd_data;
  logic                    r_timeout_pend;
  logic [31:0]             r_rsp_status;
  logic                    r_rsp_timeout;
  logic                    w_accept;
  logic [3:0]              w_np_clamped;

  assign cmd_ready    = (r_state == S_IDLE) && avl_reset_n;
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_np_clamped = (cmd_nparams > NP_MAX) ? NP_MAX : cmd_nparams;
  assign rsp_valid    = (r_state == S_DONE);
  assign rsp_status   = r_rsp_status;
  assign rsp_timeout  = r_rsp_timeout;
  assign dbg_state    = r_state;

  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) r_state <= S_IDLE;
    else              r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next_state = (w_np_clamped == 4'd0) ? S_WR_STATUS : S_WR_PARAM;
      S_WR_PARAM:  if (!avm_waitrequest && (r_idx == r_nparams - 4'd1)) w_next_state = S_WR_STATUS;
      S_WR_STATUS: if (!avm_waitrequest) w_next_state = S_WR_CMD;
      S_WR_CMD:    if (!avm_waitrequest) w_next_state = S_POLL_WAIT;
      S_POLL_WAIT: if (r_gap_cnt == GAP_LAST) w_next_state = S_RD_REQ;
      S_RD_REQ:    if (!avm_waitrequest) w_next_state = S_RD_WAIT;
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata != 32'h0)     w_next_state = S_WR_CLR;
          else if (r_poll_cnt == LIM_LAST) w_next_state = S_WR_CLR;
          else                           w_next_state = S_POLL_WAIT;
        end
      end
      S_WR_CLR:    if (!avm_waitrequest) w_next_state = S_DONE;
      S_DONE:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    avm_address   = 32'h0;
    avm_write     = 1'b0;
    avm_read      = 1'b0;
    avm_writedata = 32'h0;
    case (r_state)
      S_WR_PARAM: begin
        avm_write     = 1'b1;
        avm_address   = A_PARAM + {26'd0, r_idx, 2'b00};
        avm_writedata = r_params[31:0];
      end
      S_WR_STATUS: begin
        avm_write   = 1'b1;
        avm_address = A_STATUS;
      end
      S_WR_CMD: begin
        avm_write     = 1'b1;
        avm_address   = A_REQ;
        avm_writedata = r_code;
      end
      S_RD_REQ: begin
        avm_read    = 1'b1;
        avm_address = A_STATUS;
      end
      S_WR_CLR: begin
        avm_write   = 1'b1;
        avm_address = A_REQ;
      end
      default: ;
    endcase
  end

  // Params shift down as each word is written, so the current word is always bits [31:0].
  always_ff @(posedge avl_clk or negedge avl_reset_n) begin
    if (!avl_reset_n) begin
      r_code         <= 32'h0;
      r_nparams      <= 4'd0;
      r_idx          <= 4'd0;
      r_params       <= '0;
      r_gap_cnt      <= '0;
      r_poll_cnt     <= '0;
      r_rd_data      <= 32'h0;
      r_timeout_pend <= 1'b0;
      r_rsp_status   <= 32'h0;
      r_rsp_timeout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_code         <= cmd_code;
            r_nparams      <= w_np_clamped;
            r_params       <= cmd_params;
            r_idx          <= 4'd0;
            r_gap_cnt      <= '0;
            r_poll_cnt     <= '0;
            r_rd_data      <= 32'h0;
            r_timeout_pend <= 1'b0;
          end
        end
        S_WR_PARAM: begin
          if (!avm_waitrequest) begin
            r_idx    <= r_idx + 4'd1;
            r_params <= r_params >> 32;
          end
        end
        S_POLL_WAIT: begin
          if (r_gap_cnt == GAP_LAST)   r_gap_cnt <= '0;
          else if (r_gap_cnt != GAP_MAX) r_gap_cnt <= r_gap_cnt + GAP_W'(1);
        end
        S_RD_WAIT: begin
          if (avm_readdatavalid) begin
            if (avm_readdata != 32'h0) begin
              r_rd_data <= avm_readdata;
            end else begin
              if (r_poll_cnt != LIM_MAX) r_poll_cnt <= r_poll_cnt + LIM_W'(1);
              if (r_poll_cnt == LIM_LAST) begin
                r_timeout_pend <= 1'b1;
                r_rd_data      <= 32'h0;
              end
            end
          end
        end
        // Response registers only change on the way into DONE so they hold between commands.
        S_WR_CLR: begin
          if (!avm_waitrequest) begin
            r_rsp_status  <= r_rd_data;
            r_rsp_timeout <= r_timeout_pend;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_debug_cmd_initiator.sv
// Bench for seq_debug_cmd_initiator: Avalon slave model plus a transaction-level
// reference model of the mailbox command sequence.
module tb_seq_debug_cmd_initiator;

  localparam int          NP   = 4;
  localparam int          GAP  = 16;
  localparam int          LIM  = 4;
  localparam logic [31:0] BASE = 32'h000152a4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_code = 32'h0;
  logic [3:0]    cmd_nparams = 4'd0;
  logic [127:0]  cmd_params = '0;
  logic          rsp_valid;
  logic [31:0]   rsp_status;
  logic          rsp_timeout;
  logic [31:0]   avm_address;
  logic          avm_write;
  logic          avm_read;
  logic [31:0]   avm_writedata;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = 32'h0;
  logic          avm_readdatavalid = 1'b0;
  logic [3:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Transaction record: {is_write, address, data}; reads carry zero data.
  logic [64:0]   exp_q[$];
  logic [64:0]   obs_q[$];
  int            obs_cyc_q[$];
  int            rdv_cyc_q[$];
  logic [31:0]   rd_data_q[$];
  bit            stall_en = 0;
  int            rdv_min = 0;
  int            rdv_max = 0;
  int            proto_err = 0;
  int            n_reads = 0;
  bit            rd_pend = 0;
  int            rd_cnt = 0;
  logic [31:0]   rd_val = 32'h0;
  logic          p_rd = 0, p_wr = 0, p_wait = 0;
  logic [31:0]   p_addr = 0, p_data = 0;

  seq_debug_cmd_initiator #(
    .DEBUG_BASE(BASE), .NUM_PARAMS(NP), .POLL_GAP(GAP), .POLL_LIMIT(LIM)
  ) dut (
    .avl_clk(clk), .avl_reset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_nparams(cmd_nparams), .cmd_params(cmd_params),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_timeout(rsp_timeout),
    .avm_address(avm_address), .avm_write(avm_write), .avm_read(avm_read),
    .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Slave model: drives waitrequest/readdata on the falling edge and logs the
  // transactions that will complete on the following rising edge.
  always @(negedge clk) begin
    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rd_val;
        rd_pend           = 0;
        rdv_cyc_q.push_back(cyc);
      end else begin
        rd_cnt--;
      end
    end
    if (rst_n) begin
      if ((p_rd || p_wr) && p_wait &&
          ({avm_read, avm_write, avm_address, avm_writedata} !== {p_rd, p_wr, p_addr, p_data}))
        proto_err++;
      if (avm_read && avm_write) proto_err++;
      if (rd_pend && (avm_read || avm_write)) proto_err++;
    end
    avm_waitrequest = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
    if (avm_write && !avm_waitrequest) begin
      obs_q.push_back({1'b1, avm_address, avm_writedata});
      obs_cyc_q.push_back(cyc);
    end else if (avm_read && !avm_waitrequest) begin
      obs_q.push_back({1'b0, avm_address, 32'h0});
      obs_cyc_q.push_back(cyc);
      n_reads++;
      rd_pend = 1;
      rd_cnt  = $urandom_range(rdv_min, rdv_max);
      rd_val  = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'h0;
    end
    p_rd = avm_read; p_wr = avm_write; p_addr = avm_address;
    p_data = avm_writedata; p_wait = avm_waitrequest;
  end

  // Reference model: the mailbox transaction list and final response of one command.
  task automatic model(input logic [31:0] code, input logic [3:0] np, input logic [127:0] params,
                       input logic [31:0] plan[$], output logic [31:0] e_status, output bit e_to);
    int n;
    logic [31:0] v;
    n = (int'(np) > NP) ? NP : int'(np);
    exp_q.delete();
    for (int i = 0; i < n; i++)
      exp_q.push_back({1'b1, BASE + 32'h10 + 32'(4 * i), params[32*i +: 32]});
    exp_q.push_back({1'b1, BASE + 32'hC, 32'h0});
    exp_q.push_back({1'b1, BASE + 32'h8, code});
    e_status = 32'h0;
    e_to     = 0;
    for (int r = 0; r < LIM; r++) begin
      v = (r < plan.size()) ? plan[r] : 32'h0;
      exp_q.push_back({1'b0, BASE + 32'hC, 32'h0});
      if (v != 32'h0) begin
        e_status = v;
        break;
      end
      if (r == LIM - 1) e_to = 1;
    end
    exp_q.push_back({1'b1, BASE + 32'h8, 32'h0});
  endtask

  // Driver: present one command, wait (bounded) for its response pulse.
  task automatic do_cmd(input logic [31:0] code, input logic [3:0] np, input logic [127:0] params,
                        output bit got, output int lat, output logic [31:0] st, output bit to,
                        output bit pulse_ok);
    int acc;
    bit acc_ok;
    obs_q.delete(); obs_cyc_q.delete(); rdv_cyc_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = code; cmd_nparams = np; cmd_params = params;
    acc_ok = 0; acc = 0;
    for (int i = 0; i < 100; i++) begin
      if (cmd_ready === 1'b1) begin
        acc_ok = 1;
        acc    = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_code = $urandom; cmd_params = {$urandom, $urandom, $urandom, $urandom};
    got = 0; lat = 0; st = 32'h0; to = 0; pulse_ok = 0;
    if (acc_ok) begin
      for (int i = 0; i < 1000; i++) begin
        if (rsp_valid === 1'b1) begin
          got = 1; lat = cyc - acc; st = rsp_status; to = rsp_timeout;
          break;
        end
        @(negedge clk);
      end
    end
    if (got) begin
      pulse_ok = (cmd_ready === 1'b0);
      @(negedge clk);
      pulse_ok = pulse_ok && (rsp_valid === 1'b0) && (cmd_ready === 1'b1)
                 && (rsp_status === st) && (rsp_timeout === to);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready: got %b expected 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_status !== 32'h0) begin errors++; $display("FAIL reset_rsp_status: got %h expected 0", rsp_status); end
    checks++; if (rsp_timeout !== 1'b0) begin errors++; $display("FAIL reset_rsp_timeout: got %b expected 0", rsp_timeout); end
    checks++; if ({avm_read, avm_write} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b expected 00", {avm_read, avm_write}); end
    checks++; if ({avm_address, avm_writedata} !== 64'h0) begin errors++; $display("FAIL reset_addr_data: got %h expected 0", {avm_address, avm_writedata}); end
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_basic;
    logic [31:0] plan[$], e_st, st;
    bit e_to, to, got, pok;
    int lat;
    plan = '{32'h1};
    model(32'h3, 4'd2, {64'h0, 32'hB, 32'hA}, plan, e_st, e_to);
    rd_data_q = plan;
    do_cmd(32'h3, 4'd2, {64'h0, 32'hB, 32'hA}, got, lat, st, to, pok);
    checks++; if (!got) begin errors++; $display("FAIL basic_rsp: got none expected rsp_valid"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (st !== e_st || to !== e_to) begin errors++; $display("FAIL basic_status: got %h/%b expected %h/%b", st, to, e_st, e_to); end
    checks++; if (lat != 2 + GAP + 6) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, 2 + GAP + 6); end
    checks++; if (!pok) begin errors++; $display("FAIL basic_pulse: got bad pulse/ready/hold expected one-cycle pulse"); end
  endtask

  task automatic test_no_params;
    logic [31:0] plan[$], e_st, st, code;
    bit e_to, to, got, pok;
    int lat, rcyc[$];
    code = $urandom_range(1, 32'h7fff_ffff);
    plan = '{32'h0, 32'h0, 32'h5};
    model(code, 4'd0, 128'h0, plan, e_st, e_to);
    rd_data_q = plan;
    do_cmd(code, 4'd0, {$urandom, $urandom, $urandom, $urandom}, got, lat, st, to, pok);
    checks++; if (!got) begin errors++; $display("FAIL nop_rsp: got none expected rsp_valid"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL nop_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL nop_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
      if (obs_q[i][64] == 1'b0) rcyc.push_back(obs_cyc_q[i]);
    end
    checks++; if (st !== 32'h5 || to !== 1'b0) begin errors++; $display("FAIL nop_status: got %h/%b expected 00000005/0", st, to); end
    checks++; if (rcyc.size() != 3 || rdv_cyc_q.size() != 3) begin
      errors++; $display("FAIL nop_reads: got %0d reads expected 3", rcyc.size());
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++; if (rcyc[k] - rdv_cyc_q[k-1] - 1 != GAP) begin
          errors++; $display("FAIL nop_gap[%0d]: got %0d expected %0d", k, rcyc[k] - rdv_cyc_q[k-1] - 1, GAP);
        end
      end
    end
  endtask

  task automatic test_timeout;
    logic [31:0] plan[$], e_st, st;
    bit e_to, to, got, pok;
    int lat;
    plan = {};
    model(32'h9, 4'd1, {96'h0, 32'hC0DE}, plan, e_st, e_to);
    rd_data_q = plan;
    do_cmd(32'h9, 4'd1, {96'h0, 32'hC0DE}, got, lat, st, to, pok);
    checks++; if (!got) begin errors++; $display("FAIL timeout_rsp: got none expected rsp_valid"); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL timeout_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL timeout_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (st !== 32'h0 || to !== 1'b1) begin errors++; $display("FAIL timeout_status: got %h/%b expected 00000000/1", st, to); end
    checks++; if (!pok) begin errors++; $display("FAIL timeout_pulse: got bad pulse/ready/hold expected one-cycle pulse"); end
  endtask

  task automatic test_clamp;
    logic [31:0] plan[$], e_st, st;
    logic [127:0] prm;
    bit e_to, to, got, pok;
    int lat, nwr;
    prm  = {$urandom, $urandom, $urandom, $urandom};
    plan = '{32'h0, 32'hABCD};
    model(32'h21, 4'd7, prm, plan, e_st, e_to);
    rd_data_q = plan;
    do_cmd(32'h21, 4'd7, prm, got, lat, st, to, pok);
    nwr = 0;
    foreach (obs_q[i]) if (obs_q[i][64] && obs_q[i][63:32] >= BASE + 32'h10) nwr++;
    checks++; if (nwr != NP) begin errors++; $display("FAIL clamp_param_writes: got %0d expected %0d", nwr, NP); end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL clamp_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL clamp_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (!got || st !== e_st || to !== e_to) begin errors++; $display("FAIL clamp_status: got %h/%b expected %h/%b", st, to, e_st, e_to); end
  endtask

  task automatic test_stall;
    logic [31:0] plan[$], e_st, st;
    bit e_to, to, got, pok;
    int lat;
    stall_en = 1; rdv_min = 0; rdv_max = 5; proto_err = 0;
    for (int it = 0; it < 3; it++) begin
      plan = '{32'h1};
      model(32'h3, 4'd2, {64'h0, 32'hB, 32'hA}, plan, e_st, e_to);
      rd_data_q = plan;
      do_cmd(32'h3, 4'd2, {64'h0, 32'hB, 32'hA}, got, lat, st, to, pok);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
      end
      checks++; if (!got || st !== 32'h1 || to !== 1'b0) begin errors++; $display("FAIL stall_status: got %h/%b expected 00000001/0", st, to); end
    end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL stall_protocol: got %0d violations expected 0", proto_err); end
    stall_en = 0; rdv_max = 0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] plan[$], e_st, st;
    bit e_to, to, got, pok, seen, found;
    int lat, nobs;
    rdv_min = 20; rdv_max = 20; n_reads = 0;
    rd_data_q = '{32'h77};
    obs_q.delete();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_code = 32'h44; cmd_nparams = 4'd1; cmd_params = {96'h0, 32'h1234};
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      if (n_reads > 0) begin found = 1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL rstmid_read_seen: got no read expected one"); end
    nobs = obs_q.size();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({cmd_ready, rsp_valid, rsp_timeout, avm_read, avm_write} !== 5'b0) begin
      errors++; $display("FAIL rstmid_ctrl: got %b expected 00000", {cmd_ready, rsp_valid, rsp_timeout, avm_read, avm_write});
    end
    checks++; if ({rsp_status, avm_address, avm_writedata} !== 96'h0) begin
      errors++; $display("FAIL rstmid_data: got %h expected 0", {rsp_status, avm_address, avm_writedata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid === 1'b1) seen = 1;
      if (!rd_pend) break;
    end
    repeat (3) begin @(negedge clk); #1; if (rsp_valid === 1'b1) seen = 1; end
    checks++; if (rd_pend) begin errors++; $display("FAIL rstmid_late_rdv: got still pending expected delivered"); end
    checks++; if (seen || obs_q.size() != nobs || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_ignore: got rsp=%b txns=%0d ready=%b expected rsp=0 txns=%0d ready=1", seen, obs_q.size(), cmd_ready, nobs);
    end
    rdv_min = 0; rdv_max = 0;
    plan = '{32'h0, 32'h2};
    model(32'h55, 4'd3, {32'h0, 32'h33, 32'h22, 32'h11}, plan, e_st, e_to);
    rd_data_q = plan;
    do_cmd(32'h55, 4'd3, {32'h0, 32'h33, 32'h22, 32'h11}, got, lat, st, to, pok);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rstmid2_txn_count: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid2_txn[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (!got || st !== e_st || to !== e_to || !pok) begin errors++; $display("FAIL rstmid2_status: got %h/%b expected %h/%b", st, to, e_st, e_to); end
  endtask

  task automatic test_random;
    logic [31:0] plan[$], e_st, st, code;
    logic [127:0] prm;
    logic [3:0] np;
    bit e_to, to, got, pok;
    int lat, nz;
    proto_err = 0;
    for (int it = 0; it < 8; it++) begin
      stall_en = 1'($urandom_range(0, 1));
      rdv_max  = $urandom_range(0, 5);
      code = $urandom_range(1, 32'h7fff_ffff);
      np   = 4'($urandom_range(0, 15));
      prm  = {$urandom, $urandom, $urandom, $urandom};
      plan = {};
      nz   = $urandom_range(0, 5);
      for (int k = 0; k < nz; k++) plan.push_back(32'h0);
      plan.push_back($urandom_range(1, 32'hffff));
      model(code, np, prm, plan, e_st, e_to);
      rd_data_q = plan;
      do_cmd(code, np, prm, got, lat, st, to, pok);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_txn_count: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_txn[%0d]: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
      end
      checks++; if (!got || st !== e_st || to !== e_to || !pok) begin errors++; $display("FAIL rand%0d_status: got %h/%b expected %h/%b", it, st, to, e_st, e_to); end
    end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL rand_protocol: got %0d violations expected 0", proto_err); end
    stall_en = 0; rdv_max = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_params();
    test_timeout();
    test_clamp();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_debug_cmd_initiator.md
# seq_debug_cmd_initiator

Host-side initiator for the sequencer core debug command mailbox. Accepts one debug command at a time from a local requester, writes its parameters and command code into the mailbox over an Avalon-MM master port, polls the status word until the sequencer software reports completion or a poll limit expires, then returns the status to the requester. It sits between a debug/test controller and the sequencer's Avalon-MM slave fabric. The Nios sequencer code is the responder at the other end.

## Interface
- DEBUG_BASE, 'h000152a4: mailbox base. REQ_CMD is at base+'h8, CMD_STATUS at base+'hC, and param i at base+'h10+4*i.
- NUM_PARAMS, 4: maximum parameter words per command (1..8).
- POLL_GAP, 16: idle cycles between status reads (>=1).
- POLL_LIMIT, 1024: maximum status reads before timeout (>=1).
- avl_clk  in  1  single clock.
- avl_reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle; command accepted when valid&&ready.
- cmd_code  in  32  command word written to REQ_CMD. Must be nonzero.
- cmd_nparams  in  4  parameter words to write (0..NUM_PARAMS).
- cmd_params  in  32*NUM_PARAMS  param i in bits [32i+31:32i].
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_status  out  32  final CMD_STATUS value (0 on timeout).
- rsp_timeout  out  1  qualifies rsp_valid: poll limit reached.
- avm_address  out  32  byte address.
- avm_write  out  1  write request.
- avm_read  out  1  read request.
- avm_writedata  out  32  write data.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data strobe.

## Operation
- States: IDLE, WR_PARAM, WR_STATUS, WR_CMD, POLL_WAIT, RD_REQ, RD_WAIT, WR_CLR, DONE.
- IDLE: cmd_ready=1. On accept, register code, nparams (clamped to NUM_PARAMS) and params, then clear poll counters. If nparams=0, go to WR_STATUS; otherwise go to WR_PARAM with index 0.
- WR_PARAM: write param[idx] to base+'h10+4*idx. Advance on !waitrequest. Leave after the last word.
- WR_STATUS: write 0 to CMD_STATUS to mark it pending.
- WR_CMD: write the code to REQ_CMD.
- POLL_WAIT: count POLL_GAP cycles, then go to RD_REQ.
- RD_REQ: read CMD_STATUS. Go to RD_WAIT when accepted.
- RD_WAIT: wait for readdatavalid.
  - Data nonzero: latch it into rsp_status and go to WR_CLR.
  - Data zero: increment poll count. At POLL_LIMIT, set timeout, force status to 0, and go to WR_CLR. Otherwise go to POLL_WAIT.
- WR_CLR: write 0 to REQ_CMD so the responder sees the mailbox idle.
- DONE: pulse rsp_valid, then return to IDLE.
- At most one Avalon transaction is outstanding. read and write are never both asserted.
- readdatavalid outside RD_WAIT is ignored.

## Timing
- Reset values: cmd_ready=0 while in reset and 1 in the first cycle after release. rsp_valid=0, rsp_status=0, rsp_timeout=0. avm_read=0, avm_write=0, avm_address=0, avm_writedata=0.
- Avalon rules: address, data and strobes are held stable while waitrequest=1. A write completes in the cycle with write&&!waitrequest.
- Zero-wait-state write latency: 1 cycle per write.
- Minimum latency from accept to rsp_valid, with waitrequest=0, readdatavalid 1 cycle after the read and a first poll nonzero: nparams+POLL_GAP+6 cycles.
- rsp_status and rsp_timeout are held from DONE until the next DONE.
- rsp_valid is asserted for exactly one cycle per accepted command.
- cmd_ready=0 from the accept cycle through DONE. A command presented in the DONE cycle is not accepted until IDLE.
- Simultaneous cmd_valid at reset release: not accepted until cmd_ready is high.
- Reset mid-operation: asynchronous return to IDLE with all outputs at reset values. Mailbox contents are left as they are and no recovery write is issued.
- Counter widths: POLL_GAP and POLL_LIMIT counters use $clog2(max+1) bits. They saturate and never wrap.

## Test plan
- Setup for all scenarios: zero-wait slave model.
- cmd_code='h3, 2 params ('hA,'hB), status becomes 'h1 on 1st poll: expect writes 'hA@'h152b4, 'hB@'h152b8, 0@'h152b0, 'h3@'h152ac, then 1 read, then 0@'h152ac. Expect rsp_valid with status 'h1 and timeout=0 after 24 cycles.
- nparams=0, status becomes 'h5 on 3rd poll: no param writes, exactly 3 reads spaced POLL_GAP apart, rsp_status='h5.
- Status stuck at 0 with POLL_LIMIT=4: exactly 4 reads, clear write issued, rsp_timeout=1, rsp_status=0.
- waitrequest randomly high 50% and readdatavalid delayed 0-5 cycles: bus signals stable under stall, same write/read sequence as the first scenario, one outstanding transaction.
- Reset asserted during RD_WAIT, then a new command: outputs go to reset values immediately, a late readdatavalid is ignored, and the second command completes normally.
- nparams=7 with NUM_PARAMS=4: only 4 param writes (base+'h10..'h1C).
